// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline hazard controller.
//   DIV_CYCLES_DEFAULT : default total divider latency in cycles
//   CNT_W              : width of the divider down-counter
//   state_e            : divider / flush-recovery FSM encoding
//   seg_ctrl_t         : bundle of all segment stall/refresh/divider outputs
package pipe_ctrl_pkg;

  localparam int unsigned DIV_CYCLES_DEFAULT = 33;
  localparam int unsigned CNT_W              = 6;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DIV        = 2'd1,
    ST_DONE       = 2'd2,
    ST_FLUSH_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic mem_wb_stall;
    logic if_id_refresh;
    logic id_ex_refresh;
    logic ex_mem_refresh;
    logic mem_wb_refresh;
    logic div_busy;
    logic div_cancel;
  } seg_ctrl_t;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_div_timer.sv
// pipe_div_timer -- divider latency down-counter.
//   clk, resetn : clock, asynchronous active-low reset
//   clr_i       : force the count to zero (flush)
//   load_i      : load DIV_CYCLES-1 (divide starts)
//   dec_i       : count down by one (divide in progress)
//   cnt_gt1_o   : count is above one (divider still stalling)
//   cnt_is1_o   : terminal cycle of the divide
module pipe_div_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  output logic cnt_gt1_o,
  output logic cnt_is1_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over load so a flush in the start cycle leaves nothing behind.
  // Decrement is held at zero so a stray dec can never wrap the counter.
  always_comb begin
    // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking for all sequential state, so every flop samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

  assign cnt_gt1_o = (cnt_q > CNT_W'(1));
  assign cnt_is1_o = (cnt_q == CNT_W'(1));

endmodule : pipe_div_timer

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- five-segment pipeline stall/refresh controller.
//   Inputs : ID source regs + read enables, EX producer info (load/cp0 read,
//            regwen, wreg), divide start, fetch/data wait, exception flush.
//   Outputs: per-segment stall (hold) and refresh (bubble) controls,
//            div_busy (FSM in DIV) and div_cancel (one-cycle divider abort).
// Exactly one hazard cause drives the segment controls each cycle, in the
// order flush > data wait > divide > fetch wait/flush recovery > load-use.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_ren,
  input  logic       id_rt_ren,
  input  logic       ex_load,
  input  logic       ex_cp0ren,
  input  logic       ex_regwen,
  input  logic [4:0] ex_wreg,
  input  logic       ex_div_start,
  input  logic       inst_wait,
  input  logic       data_wait,
  input  logic       exc_flush,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       mem_wb_stall,
  output logic       if_id_refresh,
  output logic       id_ex_refresh,
  output logic       ex_mem_refresh,
  output logic       mem_wb_refresh,
  output logic       div_busy,
  output logic       div_cancel
);

  state_e    state_q;
  seg_ctrl_t ctrl_c;
  seg_ctrl_t ctrl_o;
  logic      load_use;
  logic      div_stall;
  logic      div_load;
  logic      div_dec;
  logic      cnt_gt1;
  logic      cnt_is1;

  // A value still being loaded (memory or CP0) cannot be forwarded to ID.
  assign load_use = (ex_load | ex_cp0ren) & ex_regwen & (ex_wreg != 5'd0) &
                    ((id_rs_ren & (id_rs == ex_wreg)) |
                     (id_rt_ren & (id_rt == ex_wreg)));

  // The start cycle already stalls, so the stall runs DIV_CYCLES-1 cycles and
  // releases on the cnt==1 cycle, when the quotient becomes available.
  always_comb begin
    div_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: div_stall = ex_div_start & ~exc_flush;
      ST_DIV:  div_stall = cnt_gt1;
      default: div_stall = 1'b0;
    endcase
  end

  assign div_load = (state_q == ST_IDLE) & ex_div_start & ~exc_flush;
  assign div_dec  = (state_q == ST_DIV)  & ~exc_flush;

  pipe_div_timer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clr_i     (exc_flush),
    .load_i    (div_load),
    .dec_i     (div_dec),
    .cnt_gt1_o (cnt_gt1),
    .cnt_is1_o (cnt_is1)
  );

  // Single-cause priority encoder: each branch touches a disjoint stall/refresh
  // pair per segment, so no segment is ever held and bubbled at once.
  always_comb begin
    ctrl_c          = '0;
    ctrl_c.div_busy = (state_q == ST_DIV);
    if (exc_flush) begin
      ctrl_c.if_id_refresh  = 1'b1;
      ctrl_c.id_ex_refresh  = 1'b1;
      ctrl_c.ex_mem_refresh = 1'b1;
      ctrl_c.mem_wb_refresh = 1'b1;
      ctrl_c.div_cancel     = (state_q == ST_DIV) | (state_q == ST_DONE);
    end else if (data_wait) begin
      ctrl_c.pc_stall       = 1'b1;
      ctrl_c.if_id_stall    = 1'b1;
      ctrl_c.id_ex_stall    = 1'b1;
      ctrl_c.ex_mem_stall   = 1'b1;
      ctrl_c.mem_wb_refresh = 1'b1;
    end else if (div_stall) begin
      ctrl_c.pc_stall       = 1'b1;
      ctrl_c.if_id_stall    = 1'b1;
      ctrl_c.id_ex_stall    = 1'b1;
      ctrl_c.ex_mem_refresh = 1'b1;
    end else if (inst_wait || (state_q == ST_FLUSH_WAIT)) begin
      // In FLUSH_WAIT the returning fetch belongs to the squashed path.
      ctrl_c.pc_stall       = 1'b1;
      ctrl_c.if_id_refresh  = 1'b1;
    end else if (load_use) begin
      ctrl_c.pc_stall       = 1'b1;
      ctrl_c.if_id_stall    = 1'b1;
      ctrl_c.id_ex_refresh  = 1'b1;
    end
  end

  // NOTE: outputs are gated by resetn, because several causes come straight
  // from inputs and resetting the state alone would not silence them.
  assign ctrl_o = resetn ? ctrl_c : '0;

  assign pc_stall       = ctrl_o.pc_stall;
  assign if_id_stall    = ctrl_o.if_id_stall;
  assign id_ex_stall    = ctrl_o.id_ex_stall;
  assign ex_mem_stall   = ctrl_o.ex_mem_stall;
  assign mem_wb_stall   = ctrl_o.mem_wb_stall;
  assign if_id_refresh  = ctrl_o.if_id_refresh;
  assign id_ex_refresh  = ctrl_o.id_ex_refresh;
  assign ex_mem_refresh = ctrl_o.ex_mem_refresh;
  assign mem_wb_refresh = ctrl_o.mem_wb_refresh;
  assign div_busy       = ctrl_o.div_busy;
  assign div_cancel     = ctrl_o.div_cancel;

  // DIV runs to its terminal count no matter what else stalls; DONE parks a
  // finished divide until ID/EX can advance so it is not restarted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else if (exc_flush) begin
      state_q <= inst_wait ? ST_FLUSH_WAIT : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ex_div_start) state_q <= ST_DIV;
        end
        ST_DIV: begin
          if (cnt_is1) state_q <= ctrl_c.id_ex_stall ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          if (!ctrl_c.id_ex_stall) state_q <= ST_IDLE;
        end
        ST_FLUSH_WAIT: begin
          if (!inst_wait) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl (DIV_CYCLES=33).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well before the next rising edge.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic       id_rs_ren, id_rt_ren;
  logic       ex_load, ex_cp0ren, ex_regwen, ex_div_start;
  logic       inst_wait, data_wait, exc_flush;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic       if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh;
  logic       div_busy, div_cancel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_CYCLES(33)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_ren      (id_rs_ren),
    .id_rt_ren      (id_rt_ren),
    .ex_load        (ex_load),
    .ex_cp0ren      (ex_cp0ren),
    .ex_regwen      (ex_regwen),
    .ex_wreg        (ex_wreg),
    .ex_div_start   (ex_div_start),
    .inst_wait      (inst_wait),
    .data_wait      (data_wait),
    .exc_flush      (exc_flush),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .id_ex_stall    (id_ex_stall),
    .ex_mem_stall   (ex_mem_stall),
    .mem_wb_stall   (mem_wb_stall),
    .if_id_refresh  (if_id_refresh),
    .id_ex_refresh  (id_ex_refresh),
    .ex_mem_refresh (ex_mem_refresh),
    .mem_wb_refresh (mem_wb_refresh),
    .div_busy       (div_busy),
    .div_cancel     (div_cancel)
  );

  // Bit order: pc, if_id, id_ex, ex_mem, mem_wb stalls | if_id, id_ex,
  // ex_mem, mem_wb refreshes | div_busy | div_cancel.
  logic [10:0] obs;
  assign obs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh,
                div_busy, div_cancel};

  localparam logic [10:0] O_NONE   = 11'b00000_0000_0_0;
  localparam logic [10:0] O_FLUSH  = 11'b00000_1111_0_0;
  localparam logic [10:0] O_DATA   = 11'b11110_0001_0_0;
  localparam logic [10:0] O_DIVS   = 11'b11100_0010_0_0;
  localparam logic [10:0] O_INST   = 11'b10000_1000_0_0;
  localparam logic [10:0] O_LU     = 11'b11000_0100_0_0;
  localparam logic [10:0] O_BUSY   = 11'b00000_0000_1_0;
  localparam logic [10:0] O_CANCEL = 11'b00000_0000_0_1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_wreg = 5'd0;
    id_rs_ren = 1'b0; id_rt_ren = 1'b0;
    ex_load = 1'b0; ex_cp0ren = 1'b0; ex_regwen = 1'b0; ex_div_start = 1'b0;
    inst_wait = 1'b0; data_wait = 1'b0; exc_flush = 1'b0;
  endtask

  task automatic sample();
    #1;
  endtask

  initial begin
    int stall_cnt;
    int busy_cnt;
    int cancel_cnt;
    int inst_cnt;

    // ---------------- reset: outputs silent even with active inputs
    idle_inputs();
    resetn    = 1'b0;
    exc_flush = 1'b1;
    data_wait = 1'b1;
    inst_wait = 1'b1;
    #12;
    check("reset_forced_zero", 32'(obs), 32'(O_NONE));
    idle_inputs();
    tick();
    resetn = 1'b1;
    sample();
    check("after_reset_idle", 32'(obs), 32'(O_NONE));
    tick();

    // ---------------- load-use variants
    ex_load = 1'b1; ex_regwen = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_rs_ren = 1'b1;
    sample();
    check("lu_rs_match", 32'(obs), 32'(O_LU));
    tick();
    ex_load = 1'b0;
    sample();
    check("lu_released", 32'(obs), 32'(O_NONE));
    tick();
    ex_load = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0;
    sample();
    check("lu_wreg_zero", 32'(obs), 32'(O_NONE));
    tick();
    idle_inputs();
    ex_cp0ren = 1'b1; ex_regwen = 1'b1; ex_wreg = 5'd17; id_rt = 5'd17; id_rt_ren = 1'b1;
    id_rs = 5'd17;
    sample();
    check("lu_cp0_rt_match", 32'(obs), 32'(O_LU));
    tick();
    id_rt_ren = 1'b0;
    sample();
    check("lu_ren_off", 32'(obs), 32'(O_NONE));
    tick();
    id_rt_ren = 1'b1; ex_regwen = 1'b0;
    sample();
    check("lu_no_regwen", 32'(obs), 32'(O_NONE));
    tick();
    idle_inputs();

    // ---------------- single causes and priority
    inst_wait = 1'b1;
    sample();
    check("inst_wait_only", 32'(obs), 32'(O_INST));
    tick();
    inst_wait = 1'b0; data_wait = 1'b1;
    sample();
    check("data_wait_only", 32'(obs), 32'(O_DATA));
    tick();
    ex_load = 1'b1; ex_regwen = 1'b1; ex_wreg = 5'd9; id_rs = 5'd9; id_rs_ren = 1'b1;
    inst_wait = 1'b1;
    sample();
    check("prio_data_over_all", 32'(obs), 32'(O_DATA));
    tick();
    exc_flush = 1'b1;
    sample();
    check("prio_flush_over_all", 32'(obs), 32'(O_FLUSH));
    tick();
    // The flush saw inst_wait=1, so FLUSH_WAIT discards one returning fetch.
    idle_inputs();
    sample();
    check("flush_wait_discard", 32'(obs), 32'(O_INST));
    tick();
    sample();
    check("flush_wait_to_idle", 32'(obs), 32'(O_NONE));
    tick();

    // ---------------- repeated flush while in FLUSH_WAIT
    exc_flush = 1'b1; inst_wait = 1'b1;
    sample();
    check("fw_first_flush", 32'(obs), 32'(O_FLUSH));
    tick();
    sample();
    check("fw_second_flush_no_cancel", 32'(obs), 32'(O_FLUSH));
    tick();
    exc_flush = 1'b0;
    sample();
    check("fw_still_waiting", 32'(obs), 32'(O_INST));
    tick();
    inst_wait = 1'b0;
    sample();
    check("fw_fetch_returns", 32'(obs), 32'(O_INST));
    tick();
    sample();
    check("fw_back_to_idle", 32'(obs), 32'(O_NONE));
    tick();

    // ---------------- uncontended divide: stall 32 cycles, busy 32 cycles
    stall_cnt = 0;
    busy_cnt  = 0;
    ex_div_start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (id_ex_stall && ex_mem_refresh) stall_cnt++;
      if (div_busy) busy_cnt++;
      if (i == 0)  check("div_start_cycle", 32'(obs), 32'(O_DIVS));
      if (i == 1)  check("div_first_busy", 32'(obs), 32'(O_DIVS | O_BUSY));
      if (i == 31) check("div_last_stall", 32'(obs), 32'(O_DIVS | O_BUSY));
      if (i == 32) check("div_cnt1_release", 32'(obs), 32'(O_BUSY));
      if (i == 33) check("div_back_idle", 32'(obs), 32'(O_NONE));
      // The divide leaves EX at the edge after the first unstalled cycle.
      if (!id_ex_stall) ex_div_start = 1'b0;
      tick();
    end
    check("div_stall_cycles", 32'(stall_cnt), 32'd32);
    check("div_busy_cycles", 32'(busy_cnt), 32'd32);
    idle_inputs();

    // ---------------- divide finishing under data_wait -> DONE
    for (int i = 0; i <= 37; i++) begin
      ex_div_start = (i <= 35);
      data_wait    = (i >= 32) && (i <= 34);
      sample();
      if (i == 32) check("done_entry_cycle", 32'(obs), 32'(O_DATA | O_BUSY));
      if (i == 33) check("done_holding", 32'(obs), 32'(O_DATA));
      if (i == 35) check("done_no_restart", 32'(obs), 32'(O_NONE));
      if (i == 37) check("done_to_idle", 32'(obs), 32'(O_NONE));
      tick();
    end
    idle_inputs();

    // ---------------- flush at cnt=10 (cycle 23) with a fetch still in flight
    cancel_cnt = 0;
    inst_cnt   = 0;
    for (int i = 0; i <= 30; i++) begin
      ex_div_start = (i <= 23);
      exc_flush    = (i == 23);
      inst_wait    = (i >= 23) && (i <= 26);
      sample();
      if (div_cancel) cancel_cnt++;
      if (obs == O_INST) inst_cnt++;
      if (i == 22) check("flush_pre_div", 32'(obs), 32'(O_DIVS | O_BUSY));
      if (i == 23) check("flush_cycle", 32'(obs), 32'(O_FLUSH | O_BUSY | O_CANCEL));
      if (i == 24) check("flush_wait_1", 32'(obs), 32'(O_INST));
      if (i == 27) check("flush_wait_last", 32'(obs), 32'(O_INST));
      if (i == 28) check("flush_idle", 32'(obs), 32'(O_NONE));
      tick();
    end
    check("flush_cancel_cycles", 32'(cancel_cnt), 32'd1);
    check("flush_discard_cycles", 32'(inst_cnt), 32'd4);
    idle_inputs();

    // ---------------- reset in the middle of a divide
    ex_div_start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    exc_flush = 1'b1;
    resetn    = 1'b0;
    sample();
    check("rst_mid_div_zero", 32'(obs), 32'(O_NONE));
    tick();
    check("rst_held_zero", 32'(obs), 32'(O_NONE));
    idle_inputs();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("rst_release_idle_%0d", i), 32'(obs), 32'(O_NONE));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 33, legal range 3..63: total divider latency in cycles.
REQ-002 SHALL have port clk, in, 1: sole clock, rising edge.
REQ-003 SHALL have port resetn, in, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports id_rs, id_rt, in, 5 each, and id_rs_ren, id_rt_ren, in, 1 each: ID source registers and their read enables.
REQ-005 SHALL have ports ex_load, ex_cp0ren, ex_regwen, in, 1 each, and ex_wreg, in, 5: EX-stage producer info.
REQ-006 SHALL have port ex_div_start, in, 1: a divide instruction is in EX.
REQ-007 SHALL have ports inst_wait, in, 1 (fetch outstanding) and data_wait, in, 1 (MEM data access outstanding).
REQ-008 SHALL have port exc_flush, in, 1: exception or eret taken this cycle.
REQ-009 SHALL have outputs pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall, 1 each: segment hold.
REQ-010 SHALL have outputs if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh, 1 each: segment bubble insert.
REQ-011 SHALL have outputs div_busy, 1 (FSM in DIV) and div_cancel, 1 (one-cycle divider abort).

Function
REQ-012 SHALL compute all stall/refresh outputs combinationally from inputs and registered state; one cause per cycle, chosen by the priority order below.
REQ-013 SHALL define load_use = (ex_load|ex_cp0ren) & ex_regwen & ex_wreg!=0 & ((id_rs_ren & id_rs==ex_wreg) | (id_rt_ren & id_rt==ex_wreg)).
REQ-014 SHALL, on exc_flush (priority 1), assert all four refresh outputs, no stalls, and pulse div_cancel if state is DIV or DONE.
REQ-015 SHALL, on data_wait (priority 2), assert pc/if_id/id_ex/ex_mem stall and mem_wb_refresh.
REQ-016 SHALL, on div_stall (priority 3), assert pc/if_id/id_ex stall and ex_mem_refresh.
REQ-017 SHALL, on inst_wait or state FLUSH_WAIT (priority 4), assert pc_stall and if_id_refresh.
REQ-018 SHALL, on load_use (priority 5), assert pc/if_id stall and id_ex_refresh.
REQ-019 SHALL implement FSM states IDLE, DIV, DONE, FLUSH_WAIT, plus a 6-bit down-counter cnt.
REQ-020 SHALL, in IDLE with ex_div_start and no exc_flush, load cnt=DIV_CYCLES-1 and go to DIV; div_stall is asserted in this start cycle.
REQ-021 SHALL, in DIV, decrement cnt every cycle regardless of other stalls; div_stall=1 while cnt>1.
REQ-022 SHALL, in DIV at cnt==1, deassert div_stall and go to IDLE if id_ex_stall=0, else to DONE; total div_stall length is exactly DIV_CYCLES-1 cycles when uncontended.
REQ-023 SHALL, in DONE, ignore ex_div_start, keep div_stall=0, and return to IDLE in the first cycle id_ex_stall=0.
REQ-024 SHALL, on exc_flush, clear cnt and go to FLUSH_WAIT if inst_wait=1, else to IDLE, from any state.
REQ-025 SHALL, in FLUSH_WAIT, discard the stale fetch (REQ-017 outputs) until inst_wait=0, then go to IDLE; a new exc_flush there remains in FLUSH_WAIT.
REQ-026 SHALL never assert stall and refresh on the same segment in one cycle.

Reset
REQ-027 SHALL, while resetn=0, force state=IDLE, cnt=0, and drive every output 0 regardless of inputs.
REQ-028 SHALL, on reset asserted mid-divide or mid-FLUSH_WAIT, abandon the operation without pulsing div_cancel.

Structure
REQ-029 SHALL place the FSM state encoding and the DIV_CYCLES default in shared package pipe_ctrl_pkg.
REQ-030 SHALL isolate cnt load/decrement/terminal-count logic in sub-module pipe_div_timer.

Verification
REQ-031 Load-use: ex_load=1, ex_regwen=1, ex_wreg=5, id_rs=5, id_rs_ren=1 -> pc_stall=if_id_stall=id_ex_refresh=1 for one cycle; with ex_wreg=0 -> no outputs.
REQ-032 Divide, DIV_CYCLES=33: ex_div_start pulse-and-hold -> id_ex_stall and ex_mem_refresh high exactly 32 cycles, div_busy high 32 cycles, then released and IDLE.
REQ-033 Divide + data_wait on cnt==1 cycle for 3 cycles -> state DONE, no restart while ex_div_start stays high, IDLE after data_wait drops.
REQ-034 exc_flush at cnt=10 of a divide with inst_wait=1 for 4 more cycles -> div_cancel one cycle, all refreshes one cycle, then if_id_refresh+pc_stall 4 cycles, then IDLE.
REQ-035 data_wait, load_use and inst_wait together -> only REQ-015 outputs; exc_flush added -> only REQ-014 outputs.
REQ-036 resetn low during DIV -> all outputs 0 immediately; after release with idle inputs, all outputs remain 0.
